// File: rtl/rvc_input_pkg.sv
// Shared types and constants for the button/switch input controller.
// No logic, no latency and no backpressure: declarations only.
package rvc_input_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  localparam logic [1:0] CR_BTN    = 2'd0;
  localparam logic [1:0] CR_SW     = 2'd1;
  localparam logic [1:0] CR_STICKY = 2'd2;
  localparam logic [1:0] CR_CNT    = 2'd3;

  localparam int CR_DATA_W = 32;

endpackage

// File: rtl/rvc_debounce.sv
// One raw input: 2-flop synchronizer, then a debounce FSM and stability counter.
// A clean step sampled at edge k shows on db after edge k+DEBOUNCE_CYCLES+2; no backpressure.
module rvc_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  import rvc_input_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      state  <= STABLE_LO;
      cnt    <= '0;
      db     <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      db     <= db_nxt;
    end
  end

  // db only moves when a WAIT state completes its full qualification window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = db;
    case (state)
      STABLE_LO: begin
        if (sync_b) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_b) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_b) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_b) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
        db_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rvc_input_ctrl.sv
// Debounced buttons/switches with press pulses, sticky press flags and press counters.
// Db follows a clean input after DEBOUNCE_CYCLES+2 edges; reads take 1 cycle; no backpressure.
module rvc_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = 10
) (
  input  logic            Clock,
  input  logic            Rst,
  input  logic            Button_0,
  input  logic            Button_1,
  input  logic [SW_W-1:0] Switch,
  input  logic            CrWrEn,
  input  logic [1:0]      CrAddr,
  input  logic [31:0]     CrWrData,
  output logic [31:0]     CrRdData,
  output logic [1:0]      Button_Db,
  output logic [SW_W-1:0] Switch_Db,
  output logic [1:0]      PressPulse
);
  import rvc_input_pkg::*;

  logic [1:0]           btn_raw;
  logic [1:0]           btn_db_q;
  logic [1:0]           sticky;
  logic [7:0]           cnt0;
  logic [7:0]           cnt1;
  logic                 wr_sticky;
  logic                 wr_cnt;
  logic [1:0]           clr_mask;
  logic [CR_DATA_W-1:0] rd_mux;
  logic                 unused_wr_bits;

  assign btn_raw = {Button_1, Button_0};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    rvc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (Clock),
      .rst (Rst),
      .raw (btn_raw[b]),
      .db  (Button_Db[b])
    );
  end

  for (genvar s = 0; s < SW_W; s++) begin : g_sw
    rvc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (Clock),
      .rst (Rst),
      .raw (Switch[s]),
      .db  (Switch_Db[s])
    );
  end

  // High exactly in the first cycle a debounced button reads 1.
  assign PressPulse = Button_Db & ~btn_db_q;

  assign wr_sticky      = CrWrEn && (CrAddr == CR_STICKY);
  assign wr_cnt         = CrWrEn && (CrAddr == CR_CNT);
  assign clr_mask       = wr_sticky ? CrWrData[1:0] : 2'b00;
  assign unused_wr_bits = ^CrWrData[31:2];

  always_comb begin
    rd_mux = '0;
    case (CrAddr)
      CR_BTN:    rd_mux = {30'b0, Button_Db};
      CR_SW:     rd_mux = CR_DATA_W'(Switch_Db);
      CR_STICKY: rd_mux = {30'b0, sticky};
      CR_CNT:    rd_mux = {16'b0, cnt1, cnt0};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      btn_db_q <= 2'b00;
      sticky   <= 2'b00;
      cnt0     <= 8'd0;
      cnt1     <= 8'd0;
      CrRdData <= '0;
    end else begin
      btn_db_q <= Button_Db;
      sticky   <= (sticky & ~clr_mask) | PressPulse;
      // A clear coinciding with a press restarts the count at that press.
      if (wr_cnt) begin
        cnt0 <= {7'b0, PressPulse[0]};
        cnt1 <= {7'b0, PressPulse[1]};
      end else begin
        cnt0 <= cnt0 + {7'b0, PressPulse[0]};
        cnt1 <= cnt1 + {7'b0, PressPulse[1]};
      end
      CrRdData <= rd_mux;
    end
  end

endmodule

// File: tb/tb_rvc_input_ctrl.sv
// Bench for rvc_input_ctrl with DEBOUNCE_CYCLES=4: press pulses go through a timed scoreboard,
// register reads and Db levels are compared inline in each scenario task.
module tb_rvc_input_ctrl;
  localparam int D  = 4;
  localparam int SW = 10;

  logic          Clock;
  logic          Rst;
  logic          Button_0;
  logic          Button_1;
  logic [SW-1:0] Switch;
  logic          CrWrEn;
  logic [1:0]    CrAddr;
  logic [31:0]   CrWrData;
  logic [31:0]   CrRdData;
  logic [1:0]    Button_Db;
  logic [SW-1:0] Switch_Db;
  logic [1:0]    PressPulse;

  rvc_input_ctrl #(.DEBOUNCE_CYCLES(D), .SW_W(SW)) dut (
    .Clock      (Clock),
    .Rst        (Rst),
    .Button_0   (Button_0),
    .Button_1   (Button_1),
    .Switch     (Switch),
    .CrWrEn     (CrWrEn),
    .CrAddr     (CrAddr),
    .CrWrData   (CrWrData),
    .CrRdData   (CrRdData),
    .Button_Db  (Button_Db),
    .Switch_Db  (Switch_Db),
    .PressPulse (PressPulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int at;
  } pev_t;
  pev_t pq[$];

  int n_cmp = 0;
  int n_err = 0;

  // Pulse scoreboard: every PressPulse bit must match the oldest expected event and its cycle.
  always @(posedge Clock) begin
    #1;
    while (pq.size() > 0 && pq[0].at < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL pulse_missing: idx %0d not observed, required at cycle %0d", pq[0].idx, pq[0].at);
      void'(pq.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      if (PressPulse[i]) begin
        n_cmp++;
        if (pq.size() == 0) begin
          n_err++;
          $display("FAIL pulse_unexpected: idx %0d at cycle %0d, required none", i, cyc);
        end else if (pq[0].idx != i || pq[0].at != cyc) begin
          n_err++;
          $display("FAIL pulse_match: idx %0d at cycle %0d, required idx %0d at cycle %0d",
                   i, cyc, pq[0].idx, pq[0].at);
        end else begin
          void'(pq.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  task automatic set_btn(input int idx, input logic v);
    if (idx == 0) Button_0 = v;
    else Button_1 = v;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    CrWrEn   = 1'b1;
    CrAddr   = addr;
    CrWrData = data;
    tick(1);
    CrWrEn   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
    CrAddr = addr;
    tick(1);
    n_cmp++;
    if (CrRdData !== exp) begin
      n_err++;
      $display("FAIL %s: CrRdData got %h, required %h", name, CrRdData, exp);
    end
  endtask

  // Clean press of one button; optionally a register write lands in the pulse cycle.
  task automatic press(input int idx, input logic wen, input logic [1:0] waddr,
                       input logic [31:0] wdata);
    int k;
    pev_t e;
    set_btn(idx, 1'b1);
    k = cyc + 1;
    e.idx = idx;
    e.at  = k + D + 2;
    pq.push_back(e);
    wait_until(k + D + 1);
    n_cmp++;
    if (Button_Db[idx] !== 1'b0) begin
      n_err++;
      $display("FAIL db_early idx %0d: got %b, required 0", idx, Button_Db[idx]);
    end
    wait_until(k + D + 2);
    n_cmp++;
    if (Button_Db[idx] !== 1'b1) begin
      n_err++;
      $display("FAIL db_rise idx %0d: got %b, required 1", idx, Button_Db[idx]);
    end
    if (wen) wr(waddr, wdata);
    set_btn(idx, 1'b0);
    tick(D + 5);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    Button_0 = 1'b0;
    Button_1 = 1'b0;
    Switch   = '0;
    CrWrEn   = 1'b0;
    CrAddr   = 2'd0;
    CrWrData = '0;
    tick(3);
    n_cmp++;
    if (Button_Db !== 2'b00 || Switch_Db !== '0 || PressPulse !== 2'b00 || CrRdData !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: db %b sw %h pulse %b rd %h, required all 0",
               Button_Db, Switch_Db, PressPulse, CrRdData);
    end
    Rst = 1'b0;
    tick(2);
    rd(2'd3, 32'h0, "reset_cnt");
  endtask

  task automatic test_press;
    press(0, 1'b0, 2'd0, 32'h0);
    rd(2'd2, 32'h1, "press_sticky");
    rd(2'd3, 32'h1, "press_cnt");
    rd(2'd0, 32'h0, "press_released_db");
  endtask

  task automatic test_glitch;
    wr(2'd3, 32'h0);
    for (int len = 2; len <= D - 1; len++) begin
      Button_1 = 1'b1;
      tick(len);
      Button_1 = 1'b0;
      tick(D + 6);
      n_cmp++;
      if (Button_Db !== 2'b00) begin
        n_err++;
        $display("FAIL glitch_db len %0d: got %b, required 00", len, Button_Db);
      end
    end
    rd(2'd3, 32'h0, "glitch_cnt");
    rd(2'd2, 32'h1, "glitch_sticky");
  endtask

  task automatic test_switch;
    int k;
    Switch = 10'h2A5;
    CrAddr = 2'd1;
    k = cyc + 1;
    wait_until(k + D + 2);
    n_cmp++;
    if (Switch_Db !== 10'h2A5 || CrRdData !== 32'h0) begin
      n_err++;
      $display("FAIL switch_settle: sw_db %h rd %h, required 2a5 and 0", Switch_Db, CrRdData);
    end
    wait_until(k + D + 3);
    n_cmp++;
    if (CrRdData !== 32'h2A5) begin
      n_err++;
      $display("FAIL switch_read: got %h, required 000002a5", CrRdData);
    end
  endtask

  task automatic test_regs;
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0, "ro_btn");
    wr(2'd1, 32'h0);
    rd(2'd1, 32'h2A5, "ro_sw");
    rd(2'd2, 32'h1, "ro_sticky");
  endtask

  task automatic test_sticky;
    press(1, 1'b0, 2'd0, 32'h0);
    rd(2'd2, 32'h3, "sticky_both");
    press(0, 1'b1, 2'd2, 32'h1);
    rd(2'd2, 32'h3, "sticky_set_wins");
    CrAddr   = 2'd2;
    CrWrEn   = 1'b1;
    CrWrData = 32'h3;
    tick(1);
    CrWrEn = 1'b0;
    n_cmp++;
    if (CrRdData !== 32'h3) begin
      n_err++;
      $display("FAIL sticky_prewrite: got %h, required 00000003", CrRdData);
    end
    tick(1);
    n_cmp++;
    if (CrRdData !== 32'h0) begin
      n_err++;
      $display("FAIL sticky_w1c: got %h, required 00000000", CrRdData);
    end
    rd(2'd3, 32'h0101, "sticky_cnts");
  endtask

  task automatic test_wrap;
    wr(2'd3, 32'h0);
    for (int i = 0; i < 255; i++) press(0, 1'b0, 2'd0, 32'h0);
    rd(2'd3, 32'h00FF, "cnt_255");
    press(0, 1'b0, 2'd0, 32'h0);
    rd(2'd3, 32'h0000, "cnt_wrap");
    press(0, 1'b1, 2'd3, 32'h0);
    rd(2'd3, 32'h0001, "cnt_clear_with_press");
  endtask

  task automatic test_reset_mid;
    int k2;
    pev_t e;
    Button_0 = 1'b1;
    tick(4);
    Rst = 1'b1;
    tick(2);
    n_cmp++;
    if (Button_Db !== 2'b00 || CrRdData !== 32'h0 || PressPulse !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_state: db %b rd %h pulse %b, required 0", Button_Db, CrRdData, PressPulse);
    end
    Rst = 1'b0;
    k2 = cyc + 1;
    e.idx = 0;
    e.at  = k2 + D + 2;
    pq.push_back(e);
    wait_until(k2 + D + 1);
    n_cmp++;
    if (Button_Db[0] !== 1'b0) begin
      n_err++;
      $display("FAIL requal_early: got %b, required 0", Button_Db[0]);
    end
    wait_until(k2 + D + 2);
    n_cmp++;
    if (Button_Db[0] !== 1'b1) begin
      n_err++;
      $display("FAIL requal_rise: got %b, required 1", Button_Db[0]);
    end
    Button_0 = 1'b0;
    tick(D + 5);
    rd(2'd3, 32'h1, "requal_cnt");
    rd(2'd2, 32'h1, "requal_sticky");
    rd(2'd1, 32'h2A5, "requal_sw");
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_switch();
    test_regs();
    test_sticky();
    test_wrap();
    test_reset_mid();
    tick(D + 4);
    n_cmp++;
    if (pq.size() != 0) begin
      n_err++;
      $display("FAIL pulse_leftover: %0d expected pulses never observed, required 0", pq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvc_input_ctrl.md
RVC_INPUT_CTRL -- requirements
Module: rvc_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): stable cycles required before a debounced level changes.
REQ-002 SHALL have parameter SW_W, default 10: switch count.
REQ-003 Clock  in  1  system clock; single clock domain.
REQ-004 Rst  in  1  asynchronous, active-high reset.
REQ-005 Button_0, Button_1  in  1 each  raw push-buttons, active-high (already inverted), asynchronous to Clock.
REQ-006 Switch  in  SW_W  raw slide switches, asynchronous.
REQ-007 CrWrEn  in  1  core register write strobe.
REQ-008 CrAddr  in  2  register word index.
REQ-009 CrWrData  in  32  write data.
REQ-010 CrRdData  out  32  registered read data.
REQ-011 Button_Db  out  2  debounced button levels.
REQ-012 Switch_Db  out  SW_W  debounced switch levels.
REQ-013 PressPulse  out  2  one-cycle pulse per debounced rising edge of a button.

Function
REQ-014 Each raw input SHALL pass a 2-flop synchronizer, then a per-input debounce FSM.
REQ-015 FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO -> WAIT_HI when sync=1.
- STABLE_HI -> WAIT_LO when sync=0.
- Each transition clears the counter.
REQ-016 In WAIT_x the counter SHALL increment each cycle the sync value equals the target. When the count reaches DEBOUNCE_CYCLES-1, the FSM SHALL enter STABLE_x and update the Db output. If the sync value reverts first, the FSM SHALL return to the prior STABLE state with the Db output unchanged.
REQ-017 Latency: a clean step first sampled at edge k SHALL appear on Db after edge k+DEBOUNCE_CYCLES+2; PressPulse SHALL be high for exactly that one cycle.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no Db change and no PressPulse.
REQ-019 Register map, read via CrAddr:
- 0 = {30'b0, Button_Db}
- 1 = {zero-extended Switch_Db}
- 2 = {30'b0, Sticky[1:0]}
- 3 = {16'b0, Cnt1[7:0], Cnt0[7:0]}
REQ-020 CrRdData SHALL be registered, updating every cycle from CrAddr with 1-cycle latency; a read in the same cycle as a write returns the pre-write value.
REQ-021 Sticky[i] SHALL set on PressPulse[i]. Writing offset 2 clears bits where CrWrData[i]=1 (write-1-to-clear). A set and a clear in the same cycle: set wins.
REQ-022 Cnt0/Cnt1 SHALL increment on each PressPulse, wrapping 255->0. Any write to offset 3 clears both counts. A write coinciding with a press leaves that count at 1.
REQ-023 Writes to offsets 0 and 1 SHALL be ignored.

Reset
REQ-024 On Rst all FSMs SHALL be in STABLE_LO with counters 0, and the synchronizers, Button_Db, Switch_Db, PressPulse, Sticky, Cnt0, Cnt1 and CrRdData SHALL all be 0.
REQ-025 Rst asserted mid-WAIT SHALL abort the debounce with no PressPulse. After release, an input held high SHALL re-qualify with the full REQ-017 latency.

Structure
REQ-026 Package rvc_input_pkg SHALL hold the debounce state enum, the CR offset constants (0-3) and the CR data width.
REQ-027 Sub-module rvc_debounce SHALL contain one synchronizer, FSM and counter, parameterized by DEBOUNCE_CYCLES. It SHALL be instantiated 2+SW_W times.
REQ-028 Counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1.
REQ-029 Expected size: 150-300 lines of RTL.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Button_0 held 1 from edge 10 -> Button_Db[0]=1 and PressPulse[0]=1 only after edge 16; Sticky=2'b01; Cnt0=1.
REQ-031 Button_1 pulsed high for 2 cycles, then low -> no PressPulse, Button_Db stays 0, CR offset 3 reads 0.
REQ-032 Set Switch=10'h2A5, then CrAddr=1 -> CrRdData=32'h2A5 one cycle after Switch_Db settles.
REQ-033 Sticky=2'b11, write CrWrData=1 to offset 2 in the same cycle as a new PressPulse[0] -> Sticky reads 2'b11. Next plain W1C write of 3 -> Sticky reads 2'b00.
REQ-034 256 clean presses of Button_0 -> Cnt0 wraps to 0. A write to offset 3 coinciding with a press -> Cnt0=1.
REQ-035 Assert Rst while Button_0 is in WAIT_HI -> no PressPulse. After release with the button still high -> Db rises exactly DEBOUNCE_CYCLES+2 cycles later.
